// File: rtl/dram_port_arbiter_if.sv
// Bundle of the NPU, host-loader and DRAM-side signals around the DRAM port arbiter.
// slave = arbiter side, master = requesters plus DRAM model side.
interface dram_port_arbiter_if #(
  parameter int AWIDTH    = 10,
  parameter int DWIDTH    = 80,
  parameter int LEN_WIDTH = 4
);
  logic                 npu_req;
  logic                 npu_we;
  logic [AWIDTH-1:0]    npu_addr;
  logic [DWIDTH-1:0]    npu_wdata;
  logic                 npu_gnt;
  logic [DWIDTH-1:0]    npu_rdata;
  logic                 npu_rvalid;

  logic                 host_req;
  logic                 host_we;
  logic [AWIDTH-1:0]    host_addr;
  logic [LEN_WIDTH-1:0] host_len;
  logic [DWIDTH-1:0]    host_wdata;
  logic                 host_wready;
  logic [DWIDTH-1:0]    host_rdata;
  logic                 host_rvalid;
  logic                 host_done;

  logic [AWIDTH-1:0]    dram_addr;
  logic                 dram_we;
  logic [DWIDTH-1:0]    dram_wdata;
  logic [DWIDTH-1:0]    dram_rdata;

  logic [15:0]          npu_wait_cnt;
  logic [15:0]          host_wait_cnt;

  modport slave (
    input  npu_req, npu_we, npu_addr, npu_wdata,
    output npu_gnt, npu_rdata, npu_rvalid,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_wready, host_rdata, host_rvalid, host_done,
    output dram_addr, dram_we, dram_wdata,
    input  dram_rdata,
    output npu_wait_cnt, host_wait_cnt
  );

  modport master (
    output npu_req, npu_we, npu_addr, npu_wdata,
    input  npu_gnt, npu_rdata, npu_rvalid,
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_wready, host_rdata, host_rvalid, host_done,
    input  dram_addr, dram_we, dram_wdata,
    output dram_rdata,
    input  npu_wait_cnt, host_wait_cnt
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Single DRAM port shared by NPU single beats (priority) and non-preemptible host bursts.
// Define ARB_PERF_CNT_EN to build the saturating wait-cycle performance counters.
module dram_port_arbiter #(
  parameter int AWIDTH       = 10,
  parameter int DWIDTH       = 80,
  parameter int LEN_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset_npu_n,
  dram_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, NPU, HOST, DONE} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [AWIDTH-1:0]    base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic                 we_q, we_d;
  logic                 npu_rvalid_q, npu_rvalid_d;
  logic [DWIDTH-1:0]    npu_rdata_q, npu_rdata_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic [DWIDTH-1:0]    host_rdata_q, host_rdata_d;
  logic                 starved;
  logic                 host_waiting;
  logic                 host_take;

  assign starved      = (starve_q >= SW'(STARVE_LIMIT));
  assign host_waiting = bus.host_req && ((state_q == IDLE) || (state_q == NPU));

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    base_d          = base_q;
    len_d           = len_q;
    beat_d          = beat_q;
    we_d            = we_q;
    host_take       = 1'b0;
    bus.npu_gnt     = 1'b0;
    bus.host_wready = 1'b0;
    bus.host_done   = 1'b0;
    bus.dram_addr   = '0;
    bus.dram_we     = 1'b0;
    bus.dram_wdata  = '0;

    if (host_waiting && !starved) starve_d = starve_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.host_req && (!bus.npu_req || starved)) host_take = 1'b1;
        else if (bus.npu_req)                          state_d   = NPU;
      end
      NPU: begin
        bus.npu_gnt    = bus.npu_req;
        bus.dram_addr  = bus.npu_addr;
        bus.dram_we    = bus.npu_req && bus.npu_we;
        bus.dram_wdata = bus.npu_wdata;
        if (bus.host_req && starved) host_take = 1'b1;
        else if (!bus.npu_req)       state_d   = IDLE;
      end
      HOST: begin
        // Address arithmetic is AWIDTH wide, so bursts wrap at the top of memory.
        bus.dram_addr   = base_q + AWIDTH'(beat_q);
        bus.dram_we     = we_q;
        bus.dram_wdata  = bus.host_wdata;
        bus.host_wready = we_q;
        beat_d          = beat_q + 1'b1;
        if (beat_q == len_q) state_d = DONE;
      end
      DONE: begin
        bus.host_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (host_take) begin
      state_d  = HOST;
      base_d   = bus.host_addr;
      len_d    = bus.host_len;
      we_d     = bus.host_we;
      beat_d   = '0;
      starve_d = '0;
    end
  end

  always_comb begin
    npu_rvalid_d  = (state_q == NPU) && bus.npu_req && !bus.npu_we;
    host_rvalid_d = (state_q == HOST) && !we_q;
    npu_rdata_d   = npu_rvalid_d  ? bus.dram_rdata : npu_rdata_q;
    host_rdata_d  = host_rvalid_d ? bus.dram_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      state_q       <= IDLE;
      starve_q      <= '0;
      base_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      we_q          <= 1'b0;
      npu_rvalid_q  <= 1'b0;
      npu_rdata_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      base_q        <= base_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      we_q          <= we_d;
      npu_rvalid_q  <= npu_rvalid_d;
      npu_rdata_q   <= npu_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.npu_rvalid  = npu_rvalid_q;
  assign bus.npu_rdata   = npu_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] npu_wait_q, npu_wait_d;
  logic [15:0] host_wait_q, host_wait_d;

  always_comb begin
    npu_wait_d  = npu_wait_q;
    host_wait_d = host_wait_q;
    if (bus.npu_req && !bus.npu_gnt && (npu_wait_q != 16'hFFFF)) npu_wait_d = npu_wait_q + 16'd1;
    if (host_waiting && (host_wait_q != 16'hFFFF))               host_wait_d = host_wait_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_npu_n) begin
    if (!reset_npu_n) begin
      npu_wait_q  <= '0;
      host_wait_q <= '0;
    end else begin
      npu_wait_q  <= npu_wait_d;
      host_wait_q <= host_wait_d;
    end
  end

  assign bus.npu_wait_cnt  = npu_wait_q;
  assign bus.host_wait_cnt = host_wait_q;
`else
  assign bus.npu_wait_cnt  = '0;
  assign bus.host_wait_cnt = '0;
`endif
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_dram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 80;
  localparam int LW = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset_npu_n;
  logic mem_load;
  always #5 clk = ~clk;

  dram_port_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .LEN_WIDTH(LW)) bus ();

  dram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LEN_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset_npu_n(reset_npu_n),
    .bus        (bus)
  );

  // DRAM model: combinational read, write on posedge.
  logic [DW-1:0] mem [0:1023];
  always_comb bus.dram_rdata = mem[bus.dram_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (bus.dram_we) begin
      mem[bus.dram_addr] <= bus.dram_wdata;
    end
  end

  function automatic logic [DW-1:0] pat(input int i);
    return {8'hC3, 62'(i) * 62'd1234567, 10'(i)};
  endfunction

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, expressed as pending burst addresses.
  logic [DW-1:0] m_mem [0:1023];
  logic [AW-1:0] host_q [$];
  bit            m_npu, m_done, m_hwe;
  int            m_starve, m_nwait, m_hwait;
  bit            exp_nrv, exp_hrv;
  logic [DW-1:0] exp_nrd, exp_hrd;

  // Requester agents.
  bit            npu_hold;
  logic [DW-1:0] hd [0:16];
  int            h_idx;
  int            cnt_wready, cnt_done, cnt_hrv;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int v);
`ifdef ARB_PERF_CNT_EN
    return 16'(v);
`else
    return (v > 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  function automatic logic [DW-1:0] rand80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic model_reset();
    host_q.delete();
    m_npu = 0; m_done = 0; m_hwe = 0;
    m_starve = 0; m_nwait = 0; m_hwait = 0;
    exp_nrv = 0; exp_hrv = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_npu_gnt"},     bus.npu_gnt,     '0);
    chk({tag, "_npu_rvalid"},  bus.npu_rvalid,  '0);
    chk({tag, "_npu_rdata"},   bus.npu_rdata,   '0);
    chk({tag, "_host_wready"}, bus.host_wready, '0);
    chk({tag, "_host_rvalid"}, bus.host_rvalid, '0);
    chk({tag, "_host_rdata"},  bus.host_rdata,  '0);
    chk({tag, "_host_done"},   bus.host_done,   '0);
    chk({tag, "_dram_addr"},   bus.dram_addr,   '0);
    chk({tag, "_dram_we"},     bus.dram_we,     '0);
    chk({tag, "_dram_wdata"},  bus.dram_wdata,  '0);
    chk({tag, "_npu_wait"},    bus.npu_wait_cnt,  '0);
    chk({tag, "_host_wait"},   bus.host_wait_cnt, '0);
  endtask

  task automatic cycle();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, n_rd, h_rd;
    bit e_we, e_gnt, e_wr, e_done, in_host, in_done, waiting, take, n_rv, h_rv;
    bit obs_gnt, obs_wr, obs_done;
    int starve_old;
    @(negedge clk);
    in_host = (host_q.size() != 0);
    in_done = m_done;
    e_addr = '0; e_wd = '0; e_we = 0; e_gnt = 0; e_wr = 0; e_done = 0;
    if (in_host) begin
      e_addr = host_q[0]; e_we = m_hwe; e_wd = bus.host_wdata; e_wr = m_hwe;
    end else if (in_done) begin
      e_done = 1;
    end else if (m_npu) begin
      e_gnt = bus.npu_req; e_addr = bus.npu_addr;
      e_we = bus.npu_req && bus.npu_we; e_wd = bus.npu_wdata;
    end

    chk("npu_gnt", bus.npu_gnt, e_gnt);
    chk("dram_we", bus.dram_we, e_we);
    if (in_host || e_gnt) chk("dram_addr", bus.dram_addr, e_addr);
    if (e_we) chk("dram_wdata", bus.dram_wdata, e_wd);
    chk("host_wready", bus.host_wready, e_wr);
    chk("host_done", bus.host_done, e_done);
    chk("npu_rvalid", bus.npu_rvalid, exp_nrv);
    if (exp_nrv) chk("npu_rdata", bus.npu_rdata, exp_nrd);
    chk("host_rvalid", bus.host_rvalid, exp_hrv);
    if (exp_hrv) chk("host_rdata", bus.host_rdata, exp_hrd);
    chk("npu_wait_cnt", bus.npu_wait_cnt, exp_cnt(m_nwait));
    chk("host_wait_cnt", bus.host_wait_cnt, exp_cnt(m_hwait));

    obs_gnt = bus.npu_gnt; obs_wr = bus.host_wready; obs_done = bus.host_done;
    if (obs_wr)          cnt_wready++;
    if (obs_done)        cnt_done++;
    if (bus.host_rvalid) cnt_hrv++;

    // Advance the model by one clock.
    n_rv = m_npu && !in_host && !in_done && bus.npu_req && !bus.npu_we;
    n_rd = m_mem[bus.npu_addr];
    h_rv = in_host && !m_hwe;
    h_rd = in_host ? m_mem[host_q[0]] : '0;
    if (e_we) m_mem[e_addr] = e_wd;
    exp_nrv = n_rv; exp_nrd = n_rd; exp_hrv = h_rv; exp_hrd = h_rd;

    waiting = bus.host_req && !in_host && !in_done;
    if (bus.npu_req && !e_gnt && m_nwait < 65535) m_nwait++;
    if (waiting && m_hwait < 65535) m_hwait++;
    starve_old = m_starve;
    if (waiting && m_starve < LIMIT) m_starve++;

    take = 0;
    if (in_host) begin
      void'(host_q.pop_front());
      if (host_q.size() == 0) m_done = 1;
    end else if (in_done) begin
      m_done = 0;
    end else if (!m_npu) begin
      if (bus.host_req && (!bus.npu_req || starve_old >= LIMIT)) take = 1;
      else if (bus.npu_req) m_npu = 1;
    end else begin
      if (bus.host_req && starve_old >= LIMIT) take = 1;
      else if (!bus.npu_req) m_npu = 0;
    end
    if (take) begin
      m_npu = 0; m_hwe = bus.host_we; m_starve = 0;
      for (int i = 0; i <= int'(bus.host_len); i++) host_q.push_back(AW'(int'(bus.host_addr) + i));
    end

    @(posedge clk);
    #1;
    if (obs_wr && h_idx < 16) h_idx++;
    bus.host_wdata = hd[h_idx];
    if (obs_done) bus.host_req = 1'b0;
    if (obs_gnt && !npu_hold) bus.npu_req = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic npu_issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.npu_req = 1'b1; bus.npu_we = we; bus.npu_addr = addr; bus.npu_wdata = data;
  endtask

  task automatic start_host(input logic [AW-1:0] addr, input logic [LW-1:0] len, input bit we);
    for (int i = 0; i <= 16; i++) hd[i] = rand80();
    h_idx = 0;
    bus.host_wdata = hd[0];
    bus.host_addr = addr; bus.host_len = len; bus.host_we = we;
    bus.host_req = 1'b1;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int k = 0; k < max_cycles && bus.host_req; k++) cycle();
    chk("host_burst_finished", bus.host_req, '0);
  endtask

  initial begin
    logic [DW-1:0] saved [0:3];
    bit got;
    bus.npu_req = 0; bus.npu_we = 0; bus.npu_addr = '0; bus.npu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_len = '0; bus.host_wdata = '0;
    npu_hold = 0; h_idx = 0; cnt_wready = 0; cnt_done = 0; cnt_hrv = 0;
    for (int i = 0; i <= 16; i++) hd[i] = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = pat(i);
    model_reset();
    mem_load = 1'b1;
    reset_npu_n = 1'b1;
    #2 reset_npu_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    mem_load = 1'b0;
    chk_all_zero("reset");
    reset_npu_n = 1'b1;
    run(2);

    // NPU read alone at address 5.
    npu_issue(0, 10'd5, '0);
    run(4);

    // Host write burst of four beats at 10.
    cnt_wready = 0; cnt_done = 0;
    start_host(10'd10, 4'd3, 1);
    for (int i = 0; i < 4; i++) saved[i] = hd[i];
    wait_done(30);
    run(2);
    chk("wready_pulses", 80'(cnt_wready), 80'd4);
    chk("done_pulses", 80'(cnt_done), 80'd1);
    for (int i = 0; i < 4; i++) chk("burst_mem", mem[10 + i], saved[i]);

    // Read burst wrapping past the top address.
    cnt_hrv = 0;
    start_host(10'd1022, 4'd3, 0);
    wait_done(30);
    run(3);
    chk("wrap_rvalid_beats", 80'(cnt_hrv), 80'd4);

    // Starvation: NPU holds its request continuously.
    npu_hold = 1;
    npu_issue(0, 10'd20, '0);
    run(3);
    start_host(10'd100, 4'd1, 0);
    wait_done(60);
    run(4);
    npu_hold = 0;
    run(4);

    // Contention: both request together from IDLE.
    npu_issue(1, 10'd300, rand80());
    start_host(10'd300, 4'd2, 0);
    wait_done(40);
    run(3);

    // Reset in the middle of an eight-beat write burst.
    cnt_wready = 0; cnt_done = 0;
    start_host(10'd200, 4'd7, 1);
    for (int k = 0; k < 20 && cnt_wready < 2; k++) cycle();
    #1 reset_npu_n = 1'b0;
    #1 chk_all_zero("midburst_reset");
    chk("midburst_no_done", 80'(cnt_done), 80'd0);
    bus.host_req = 1'b0; bus.npu_req = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_npu_n = 1'b1;
    run(2);
    npu_issue(0, 10'd201, '0);
    run(3);
    start_host(10'd198, 4'd4, 0);
    wait_done(30);
    run(2);

    // Random mixed traffic.
    for (int c = 0; c < 800; c++) begin
      if (!bus.npu_req && $urandom_range(0, 2) != 0)
        npu_issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), rand80());
      if (!bus.host_req && $urandom_range(0, 24) == 0)
        start_host(AW'($urandom_range(0, 1023)), LW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cycle();
    end
    bus.npu_req = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && bus.host_req; k++) cycle();
    chk("final_host_idle", bus.host_req, '0);
    run(3);
    for (int i = 0; i < 1024; i++) chk("final_mem", mem[i], m_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single DRAM port between two requesters: the NPU (single-beat reads/writes on its dram_addr/dram_write_enable path) and the host loader (burst preload of weights/inputs, burst readback of results).
- Sits between NPU and the dram model.
- Fixed priority to NPU, with anti-starvation for host.
- Host bursts are non-preemptible.

Parameters:
- AWIDTH, 10, DRAM address width (matches VRF_AWIDTH).
- DWIDTH, 80, DRAM data width (matches VRF_DWIDTH).
- LEN_WIDTH, 4, host burst length field; burst = host_len+1 beats (1..16).
- STARVE_LIMIT, 8, host-waiting cycles after which host wins over NPU.

Ports:
- clk  in  1  clock, all state on posedge.
- reset_npu_n  in  1  asynchronous, active-low reset.
- npu_req  in  1  NPU beat request, held until granted.
- npu_we  in  1  1=write, 0=read.
- npu_addr  in  AWIDTH  NPU beat address.
- npu_wdata  in  DWIDTH  NPU write data.
- npu_gnt  out  1  beat issued to DRAM this cycle.
- npu_rdata  out  DWIDTH  registered read data.
- npu_rvalid  out  1  npu_rdata valid.
- host_req  in  1  burst request, held until host_done.
- host_we  in  1  burst direction.
- host_addr  in  AWIDTH  burst base address.
- host_len  in  LEN_WIDTH  beats minus one.
- host_wdata  in  DWIDTH  current write beat data.
- host_wready  out  1  write beat consumed; host advances data.
- host_rdata  out  DWIDTH  registered read data.
- host_rvalid  out  1  host_rdata valid.
- host_done  out  1  one-cycle pulse after last beat issued.
- dram_addr  out  AWIDTH  to dram addr.
- dram_we  out  1  to dram we.
- dram_wdata  out  DWIDTH  to dram in.
- dram_rdata  in  DWIDTH  from dram out (combinational read).
- npu_wait_cnt  out  16  perf counter (see Optional Feature).
- host_wait_cnt  out  16  perf counter (see Optional Feature).

Behaviour:
- Reset: async on reset_npu_n low.
  - State goes to IDLE.
  - All outputs 0; counters, starve_cnt and burst registers 0.
  - Any in-flight burst is abandoned, with no host_done.
- FSM states:
  - IDLE:
    - dram_we=0, no grants.
    - Next state HOST if host_req && (!npu_req || starve_cnt>=STARVE_LIMIT).
    - Else next state NPU if npu_req.
    - On entry to HOST, latch host_addr, host_len, host_we; beat_cnt=0.
  - NPU:
    - npu_gnt=npu_req; dram_addr=npu_addr; dram_we=npu_req&npu_we; dram_wdata=npu_wdata.
    - Back-to-back beats, one per cycle, while npu_req high.
    - Next state HOST (with latch) if host_req && starve_cnt>=STARVE_LIMIT.
    - Next state IDLE if !npu_req.
  - HOST:
    - dram_addr = base+beat_cnt, wrapping modulo 2^AWIDTH.
    - dram_we = latched we; dram_wdata = host_wdata.
    - host_wready = latched we, one pulse per beat.
    - beat_cnt++ each cycle.
    - When beat_cnt==len, go to DONE.
  - DONE: host_done=1 for one cycle; next state IDLE. host_req still high in IDLE is a new burst.
- Read latency: read beat issued in cycle N gives rdata/rvalid to the owner in cycle N+1 (registered capture of dram_rdata). rvalid is 0 on every cycle with no read beat.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle host_req=1 and state not in {HOST, DONE}.
  - Clears on HOST entry.
- Write-after-read to same address in consecutive NPU beats: ordering is preserved, since the port is single and in-order.
- Simultaneous npu_req and host_req in IDLE with starve_cnt<LIMIT: NPU wins.
- npu_req during HOST: npu_gnt=0; NPU holds its request.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - npu_wait_cnt increments every cycle npu_req=1 && npu_gnt=0.
  - host_wait_cnt increments every cycle host_req=1 and state not in {HOST, DONE}.
  - Both 16-bit, saturating at 16'hFFFF, cleared only by reset.
- Not defined: both outputs tied to 0 and no counter registers are instantiated.

Test Plan:
- NPU read alone: npu_req=1, we=0, addr=5 for 1 cycle -> dram_addr=5, npu_gnt=1 that cycle; next cycle npu_rvalid=1, npu_rdata=mem[5].
- Host write burst: host_addr=10, host_len=3, we=1, data D0..D3 -> mem[10..13]=D0..D3, four host_wready pulses, then host_done one cycle; then IDLE.
- Wrap: host_addr=1022, len=3, read -> dram_addr 1022,1023,0,1; host_rvalid four consecutive cycles one cycle later.
- Starvation: npu_req held continuously, host_req asserted -> host granted exactly 8 cycles after host_req; NPU stalls (npu_gnt=0) during the burst and resumes after DONE+IDLE.
- Contention: npu_req and host_req rise together in IDLE -> NPU granted first; host granted after npu_req drops.
- Reset mid-burst: reset_npu_n low during beat 2 of 8 -> all outputs 0 immediately, no host_done; post-reset requests served normally; with ARB_PERF_CNT_EN, counters read 0.
